// File: rtl/gpu_cmd_pkg.sv
// rtl/gpu_cmd_pkg.sv - shared types for the GPU host command interface
//
// Purpose: header layout, opcode values and widths shared by the host-side
// transmitter and the GPU-side command processor.
// Ports: none (package).

package gpu_cmd_pkg;

  localparam int CMD_W     = 64;
  localparam int CMD_LEN_W = 4;

  typedef enum logic [7:0] {
    NOP      = 8'h00,
    DRAW     = 8'h01,
    DISPATCH = 8'h02,
    FENCE    = 8'h03
  } cmd_opcode_e;

  // Field order matches the wire format, MSB first:
  // [63:56] opcode, [55:52] len, [51:36] seq, [35:32] rsvd, [31:0] arg.
  typedef struct packed {
    logic [7:0]           opcode;
    logic [CMD_LEN_W-1:0] len;
    logic [15:0]          seq;
    logic [3:0]           rsvd;
    logic [31:0]          arg;
  } cmd_hdr_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_PAY  = 1'b1
  } tx_state_e;

endpackage

// File: rtl/host_cmd_tx.sv
// rtl/host_cmd_tx.sv - host-side packet serialiser for the GPU command link
//
// Purpose: accepts a packet descriptor and its payload words and emits one
// header beat followed by pkt_len payload beats on host_cmd_*, through a
// single registered output stage.
// Ports:
//   clk_2GHz, rst_n                 clock, asynchronous active-low reset
//   pkt_valid/pkt_ready             descriptor handshake
//   pkt_opcode/pkt_len/pkt_arg      descriptor fields (sampled at handshake)
//   pl_data/pl_valid/pl_ready       payload word handshake
//   host_cmd_data/valid/ready       beat output towards the GPU
//   seq_num                         sequence number of the next header
//   beats_sent                      saturating count of accepted beats
//   stall_timeout                   sticky backpressure-timeout flag
//   busy                            packet in progress or beat pending

module host_cmd_tx
  import gpu_cmd_pkg::*;
#(
  parameter int SEQ_W       = 16,
  parameter int STALL_LIMIT = 1024
) (
  input  logic              clk_2GHz,
  input  logic              rst_n,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [7:0]        pkt_opcode,
  input  logic [3:0]        pkt_len,
  input  logic [31:0]       pkt_arg,
  input  logic [63:0]       pl_data,
  input  logic              pl_valid,
  output logic              pl_ready,
  output logic [63:0]       host_cmd_data,
  output logic              host_cmd_valid,
  input  logic              host_cmd_ready,
  output logic [SEQ_W-1:0]  seq_num,
  output logic [31:0]       beats_sent,
  output logic              stall_timeout,
  output logic              busy
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

  tx_state_e            state_q, state_d;
  logic [CMD_LEN_W-1:0] rem_q;
  logic [CMD_W-1:0]     out_reg;
  logic                 out_valid;
  logic [SEQ_W-1:0]     seq_q;
  logic [31:0]          beats_q;
  logic [STALL_W-1:0]   stall_q;
  logic                 timeout_q;
  logic                 busy_q;

  logic                 out_free;
  logic                 load_hdr;
  logic                 load_pl;
  logic                 valid_d;
  cmd_hdr_t             hdr;

  // The output register can take a new beat when empty or draining this cycle.
  assign out_free = !out_valid || host_cmd_ready;

  always_comb begin
    hdr        = '0;
    hdr.opcode = pkt_opcode;
    hdr.len    = pkt_len;
    hdr.seq    = 16'(seq_q);
    hdr.rsvd   = 4'h0;
    hdr.arg    = pkt_arg;
  end

  always_comb begin
    state_d   = state_q;
    pkt_ready = 1'b0;
    pl_ready  = 1'b0;
    load_hdr  = 1'b0;
    load_pl   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        pkt_ready = out_free;
        if (pkt_valid && out_free) begin
          load_hdr = 1'b1;
          if (pkt_len != '0) state_d = TX_PAY;
        end
      end
      TX_PAY: begin
        pl_ready = out_free;
        if (pl_valid && out_free) begin
          load_pl = 1'b1;
          // Last payload word: return to IDLE on the edge that loads it.
          if (rem_q == CMD_LEN_W'(1)) state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // A free output register with nothing to load drops valid.
  always_comb begin
    valid_d = out_valid;
    if (load_hdr || load_pl) valid_d = 1'b1;
    else if (out_free)       valid_d = 1'b0;
  end

  always_ff @(posedge clk_2GHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= TX_IDLE;
      rem_q     <= '0;
      out_reg   <= '0;
      out_valid <= 1'b0;
      seq_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      busy_q    <= (state_d == TX_PAY) || valid_d;
      if (load_hdr) begin
        out_reg <= hdr;
        rem_q   <= pkt_len;
        seq_q   <= seq_q + 1'b1;
      end else if (load_pl) begin
        out_reg <= pl_data;
        rem_q   <= rem_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_2GHz or negedge rst_n) begin
    if (!rst_n) begin
      beats_q <= '0;
    end else if (out_valid && host_cmd_ready && (beats_q != '1)) begin
      beats_q <= beats_q + 1'b1;
    end
  end

  // Consecutive-stall counter; saturates at the limit, flag is sticky.
  always_ff @(posedge clk_2GHz or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else if (out_valid && !host_cmd_ready) begin
      if (stall_q != STALL_MAX) begin
        stall_q <= stall_q + 1'b1;
        if (stall_q == STALL_MAX - 1'b1) timeout_q <= 1'b1;
      end
    end else begin
      stall_q <= '0;
    end
  end

  assign host_cmd_data  = out_reg;
  assign host_cmd_valid = out_valid;
  assign seq_num        = seq_q;
  assign beats_sent     = beats_q;
  assign stall_timeout  = timeout_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_host_cmd_tx.sv
// tb/tb_host_cmd_tx.sv - self-checking bench for host_cmd_tx
module tb_host_cmd_tx;

  localparam int SEQ_W       = 4;
  localparam int STALL_LIMIT = 8;
  localparam int NPKT        = 20;

  logic              clk_2GHz = 1'b0;
  logic              rst_n = 1'b0;
  logic              pkt_valid = 1'b0;
  logic              pkt_ready;
  logic [7:0]        pkt_opcode = '0;
  logic [3:0]        pkt_len = '0;
  logic [31:0]       pkt_arg = '0;
  logic [63:0]       pl_data = '0;
  logic              pl_valid = 1'b0;
  logic              pl_ready;
  logic [63:0]       host_cmd_data;
  logic              host_cmd_valid;
  logic              host_cmd_ready = 1'b0;
  logic [SEQ_W-1:0]  seq_num;
  logic [31:0]       beats_sent;
  logic              stall_timeout;
  logic              busy;

  host_cmd_tx #(.SEQ_W(SEQ_W), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clk_2GHz(clk_2GHz), .rst_n(rst_n),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_opcode(pkt_opcode), .pkt_len(pkt_len), .pkt_arg(pkt_arg),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .host_cmd_data(host_cmd_data), .host_cmd_valid(host_cmd_valid),
    .host_cmd_ready(host_cmd_ready),
    .seq_num(seq_num), .beats_sent(beats_sent),
    .stall_timeout(stall_timeout), .busy(busy)
  );

  always #5 clk_2GHz = ~clk_2GHz;

  int n_asserts = 0;
  int n_fail = 0;
  int model_seq = 0;
  int exp_beats = 0;
  int hold_viol = 0;
  logic [63:0] got[$];
  logic [63:0] exp_q[$];

  // Every accepted beat, in order.
  always @(posedge clk_2GHz)
    if (rst_n && host_cmd_valid && host_cmd_ready) got.push_back(host_cmd_data);

  // Valid/data must hold across a stalled edge.
  logic        pv = 1'b0, pr = 1'b0;
  logic [63:0] pd = '0;
  always @(posedge clk_2GHz) begin
    if (!rst_n) begin
      pv <= 1'b0;
    end else begin
      if (pv && !pr && (host_cmd_valid !== 1'b1 || host_cmd_data !== pd))
        hold_viol <= hold_viol + 1;
      pv <= host_cmd_valid;
      pr <= host_cmd_ready;
      pd <= host_cmd_data;
    end
  end

  function automatic logic [63:0] model_hdr(int op, int len, int seq, logic [31:0] arg);
    return (64'(op) << 56) | (64'(len) << 52) | (64'(seq % 16) << 36) | 64'(arg);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_2GHz);
    #1;
  endtask

  task automatic send_desc(input int op, input int len, input logic [31:0] arg);
    pkt_valid  = 1'b1;
    pkt_opcode = 8'(op);
    pkt_len    = 4'(len);
    pkt_arg    = arg;
  endtask

  int          p_op [NPKT];
  int          p_len[NPKT];
  logic [31:0] p_arg[NPKT];
  logic [63:0] p_pay[NPKT][16];

  initial begin
    logic [63:0] h;
    int pi, wi, cyc, zero_run;
    bit desc_done;

    // Reset values
    repeat (3) @(posedge clk_2GHz);
    #1;
    chk("rst_data", host_cmd_data, 0);
    chk("rst_valid", host_cmd_valid, 0);
    chk("rst_seq", seq_num, 0);
    chk("rst_beats", beats_sent, 0);
    chk("rst_timeout", stall_timeout, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick;
    chk("idle_pkt_ready", pkt_ready, 1);
    chk("idle_pl_ready", pl_ready, 0);

    // Zero-length packet
    host_cmd_ready = 1'b1;
    send_desc(3, 0, 32'hDEADBEEF);
    model_seq++;
    tick;
    pkt_valid = 1'b0;
    chk("zl_data", host_cmd_data, 64'h0300_0000_DEAD_BEEF);
    chk("zl_valid", host_cmd_valid, 1);
    chk("zl_seq", seq_num, 1);
    tick;
    exp_beats = 1;
    chk("zl_valid_drop", host_cmd_valid, 0);
    chk("zl_beats", beats_sent, 32'(exp_beats));

    // Streaming, ready held high
    h = model_hdr(1, 3, model_seq, 32'h0000_1111);
    model_seq++;
    send_desc(1, 3, 32'h0000_1111);
    tick;
    pkt_valid = 1'b0;
    chk("st_hdr", host_cmd_data, h);
    chk("st_pl_ready", pl_ready, 1);
    pl_valid = 1'b1;
    pl_data  = 64'hA;
    tick;
    chk("st_a", host_cmd_data, 64'hA);
    pl_data = 64'hB;
    tick;
    chk("st_b", host_cmd_data, 64'hB);
    pl_data = 64'hC;
    tick;
    chk("st_c", host_cmd_data, 64'hC);
    chk("st_c_valid", host_cmd_valid, 1);
    pl_valid = 1'b0;
    chk("st_pl_ready_low", pl_ready, 0);
    chk("st_pkt_ready", pkt_ready, 1);
    h = model_hdr(0, 0, model_seq, 32'h0000_2222);
    model_seq++;
    send_desc(0, 0, 32'h0000_2222);
    tick;
    pkt_valid = 1'b0;
    chk("st_next_hdr", host_cmd_data, h);
    chk("st_next_valid", host_cmd_valid, 1);
    tick;
    exp_beats += 5;
    chk("st_beats", beats_sent, 32'(exp_beats));

    // Backpressure on payload B
    got.delete();
    exp_q.delete();
    h = model_hdr(2, 3, model_seq, 32'h0000_3333);
    model_seq++;
    exp_q.push_back(h);
    exp_q.push_back(64'hA1);
    exp_q.push_back(64'hB2);
    exp_q.push_back(64'hC3);
    send_desc(2, 3, 32'h0000_3333);
    tick;
    pkt_valid = 1'b0;
    pl_valid  = 1'b1;
    pl_data   = 64'hA1;
    tick;
    pl_data = 64'hB2;
    tick;
    host_cmd_ready = 1'b0;
    pl_data = 64'hC3;
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("bp_hold_data", host_cmd_data, 64'hB2);
      chk("bp_hold_valid", host_cmd_valid, 1);
      chk("bp_pl_ready", pl_ready, 0);
      chk("bp_busy", busy, 1);
    end
    host_cmd_ready = 1'b1;
    tick;
    pl_valid = 1'b0;
    chk("bp_c", host_cmd_data, 64'hC3);
    tick;
    chk("bp_drained", host_cmd_valid, 0);
    chk("bp_idle_busy", busy, 0);
    exp_beats += 4;
    chk("bp_beats", beats_sent, 32'(exp_beats));
    chk("bp_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("bp_beat%0d", i), got[i], exp_q[i]);
    chk("bp_no_timeout", stall_timeout, 0);

    // Randomised packets against the queue model
    got.delete();
    exp_q.delete();
    for (int p = 0; p < NPKT; p++) begin
      p_op[p]  = int'($urandom_range(0, 3));
      p_len[p] = (p % 5 == 0) ? 0 : int'($urandom_range(0, 15));
      p_arg[p] = $urandom;
      exp_q.push_back(model_hdr(p_op[p], p_len[p], model_seq, p_arg[p]));
      model_seq++;
      for (int w = 0; w < 16; w++) begin
        p_pay[p][w] = {$urandom, $urandom};
        if (w < p_len[p]) exp_q.push_back(p_pay[p][w]);
      end
    end
    pi = 0; wi = 0; cyc = 0; zero_run = 0; desc_done = 0;
    while (pi < NPKT && cyc < 4000) begin
      if (zero_run >= 4) host_cmd_ready = 1'b1;
      else host_cmd_ready = ($urandom_range(0, 9) < 7);
      zero_run = host_cmd_ready ? 0 : zero_run + 1;
      if (!desc_done) begin
        pl_valid  = 1'b0;
        pl_data   = {$urandom, $urandom};
        pkt_valid = ($urandom_range(0, 3) != 0);
        if (pkt_valid) begin
          pkt_opcode = 8'(p_op[pi]);
          pkt_len    = 4'(p_len[pi]);
          pkt_arg    = p_arg[pi];
        end else begin
          pkt_opcode = 8'($urandom);
          pkt_len    = 4'($urandom);
          pkt_arg    = $urandom;
        end
      end else begin
        pkt_valid  = 1'b0;
        pkt_opcode = 8'($urandom);
        pl_valid   = ($urandom_range(0, 3) != 0);
        pl_data    = pl_valid ? p_pay[pi][wi] : {$urandom, $urandom};
      end
      @(negedge clk_2GHz);
      if (pkt_valid && pkt_ready) begin
        desc_done = 1;
        wi = 0;
        if (p_len[pi] == 0) begin
          pi++;
          desc_done = 0;
        end
      end else if (pl_valid && pl_ready) begin
        wi++;
        if (wi == p_len[pi]) begin
          pi++;
          desc_done = 0;
        end
      end
      @(posedge clk_2GHz);
      #1;
      cyc++;
    end
    pkt_valid = 1'b0;
    pl_valid = 1'b0;
    host_cmd_ready = 1'b1;
    repeat (4) tick;
    chk("rnd_all_sent", pi, NPKT);
    chk("rnd_count", got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("rnd_beat%0d", i), got[i], exp_q[i]);
    exp_beats += exp_q.size();
    chk("rnd_beats", beats_sent, 32'(exp_beats));
    chk("rnd_idle", busy, 0);

    // Stall timeout
    host_cmd_ready = 1'b0;
    send_desc(0, 0, 32'h0000_4444);
    model_seq++;
    tick;
    pkt_valid = 1'b0;
    for (int k = 1; k <= STALL_LIMIT; k++) begin
      tick;
      chk($sformatf("to_stall%0d", k), stall_timeout, (k >= STALL_LIMIT) ? 1 : 0);
    end
    host_cmd_ready = 1'b1;
    tick;
    tick;
    exp_beats++;
    chk("to_sticky", stall_timeout, 1);
    chk("to_drained", host_cmd_valid, 0);
    chk("to_beats", beats_sent, 32'(exp_beats));

    // Reset in the middle of a payload
    send_desc(1, 5, 32'h0000_5555);
    tick;
    pkt_valid = 1'b0;
    pl_valid  = 1'b1;
    pl_data   = 64'hF1;
    tick;
    pl_data = 64'hF2;
    tick;
    chk("mr_pre_valid", host_cmd_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_data", host_cmd_data, 0);
    chk("mr_valid", host_cmd_valid, 0);
    chk("mr_seq", seq_num, 0);
    chk("mr_beats", beats_sent, 0);
    chk("mr_timeout", stall_timeout, 0);
    chk("mr_busy", busy, 0);
    tick;
    rst_n = 1'b1;
    model_seq = 0;
    got.delete();
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("mr_pkt_ready", pkt_ready, 1);
      chk("mr_pl_ready", pl_ready, 0);
      chk("mr_no_beat", host_cmd_valid, 0);
    end
    chk("mr_no_leftover", got.size(), 0);
    pl_valid = 1'b0;

    // Sequence wrap with back-to-back zero-length headers
    host_cmd_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send_desc(0, 0, 32'(i));
      tick;
    end
    pkt_valid = 1'b0;
    tick;
    tick;
    chk("sw_count", got.size(), 17);
    for (int i = 0; i < got.size(); i++) begin
      h = got[i];
      chk($sformatf("sw_seq%0d", i), h[51:36], 16'(i % 16));
      chk($sformatf("sw_arg%0d", i), h[31:0], 32'(i));
    end
    chk("sw_seq_num", seq_num, 1);

    chk("hold_rule", hold_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/host_cmd_tx.md
Name: host_cmd_tx

Overview:
- Host-side transmitter for the GPU host command interface (`host_cmd_data` / `host_cmd_valid` / `host_cmd_ready`). The GPU core's command processor is the receiver on the other end.
- Takes a packet descriptor (opcode, length, argument) plus a stream of payload words. Serialises them into 64-bit beats: one header beat, then `pkt_len` payload beats.
- Used on the SoC host side and as the stimulus-side transmitter in GPU top-level testbenches.

Parameters:
- `SEQ_W`, 16, sequence counter width (1..16); zero-extended into the 16-bit header seq field.
- `STALL_LIMIT`, 1024, consecutive backpressure cycles before `stall_timeout` sets (>=2).

Ports:
- `clk_2GHz`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `pkt_valid`  in  1  descriptor valid
- `pkt_ready`  out  1  descriptor accepted when valid&ready
- `pkt_opcode`  in  8  command opcode
- `pkt_len`  in  4  payload beat count, 0..15
- `pkt_arg`  in  32  header argument
- `pl_data`  in  64  payload word
- `pl_valid`  in  1  payload valid
- `pl_ready`  out  1  payload accepted when valid&ready
- `host_cmd_data`  out  64  beat to GPU
- `host_cmd_valid`  out  1  beat valid
- `host_cmd_ready`  in  1  GPU accepts beat
- `seq_num`  out  SEQ_W  sequence number the next header will carry
- `beats_sent`  out  32  accepted-beat counter, saturating
- `stall_timeout`  out  1  sticky backpressure-timeout flag
- `busy`  out  1  packet in progress or beat pending

Behaviour:
- Reset is asynchronous. While `rst_n` is low, every register clears:
  - outputs `host_cmd_data`, `host_cmd_valid`, `seq_num`, `beats_sent`, `stall_timeout`, `busy` are all 0;
  - state is IDLE.
- Reset mid-packet discards the partial packet. No further beats of it are ever sent.
- Output path is a single output register (`out_reg` plus `host_cmd_valid`). No combinational path from any input to `host_cmd_valid` or `host_cmd_data`.
- Define `out_free` = `!host_cmd_valid || host_cmd_ready`.
- Valid hold rule: once `host_cmd_valid` = 1, `host_cmd_valid` and `host_cmd_data` stay stable until the cycle `host_cmd_ready` = 1.
- Header format:
  - [63:56] opcode
  - [55:52] len
  - [51:36] seq, zero-extended
  - [35:32] 4'h0
  - [31:0] arg
- FSM states: IDLE, PAY.
- IDLE:
  - `pkt_ready` = `out_free`; `pl_ready` = 0.
  - On descriptor handshake: load header into the output register, set `host_cmd_valid` = 1, `seq_num` += 1 (wraps to 0 at 2^SEQ_W), latch remaining = `pkt_len`.
  - If `pkt_len` = 0, stay IDLE. Back-to-back headers at 1 per cycle are allowed.
  - Otherwise go to PAY.
- PAY:
  - `pkt_ready` = 0; `pl_ready` = `out_free`.
  - On payload handshake: load `pl_data`, set `host_cmd_valid` = 1, remaining -= 1.
  - When remaining reaches 0, go to IDLE on the same edge.
- If `out_free` is true but no new beat is loaded that cycle, `host_cmd_valid` clears to 0.
- Latency: a beat appears on `host_cmd_data` 1 cycle after its input handshake. Sustained throughput is 1 beat/cycle.
- `beats_sent`: increments on each `host_cmd_valid && host_cmd_ready`; holds at 32'hFFFF_FFFF.
- Stall counter:
  - increments on cycles where `host_cmd_valid && !host_cmd_ready`;
  - clears on handshake or when `host_cmd_valid` = 0;
  - when it reaches `STALL_LIMIT`, `stall_timeout` is set on that edge and stays set until reset.
  - The counter saturates at `STALL_LIMIT`.
- `busy` = (state == PAY) || `host_cmd_valid`, registered-equivalent (a function of registers only).
- `pkt_opcode`, `pkt_len` and `pkt_arg` are sampled only at the descriptor handshake. `pl_data` is sampled only at the payload handshake.

Decomposition:
- Package `gpu_cmd_pkg`:
  - `cmd_hdr_t` packed struct (opcode, len, seq, rsvd, arg);
  - `cmd_opcode_e` enum: NOP=8'h00, DRAW=8'h01, DISPATCH=8'h02, FENCE=8'h03;
  - localparams `CMD_W`=64 and `CMD_LEN_W`=4.
- The receiver-side command processor shares this package.
- No sub-module: the FSM, output register and counters are a single module.

Test Plan:
- Reset: assert `rst_n`=0 mid-PAY with `host_cmd_valid`=1 -> all outputs 0 immediately (asynchronous). After release, `pkt_ready`=1 (IDLE) and no leftover payload beat appears.
- Zero-length packet: opcode 8'h03, len 0, arg 32'hDEADBEEF, `host_cmd_ready`=1 -> next cycle `host_cmd_data`=64'h0300_0000_DEAD_BEEF with valid=1 for one cycle; `seq_num`=1; `beats_sent`=1.
- Streaming: opcode 8'h01, len 3, payload 64'hA, 64'hB, 64'hC, ready held 1 -> 4 consecutive valid beats (header seq 0, then A, B, C); `pl_ready` low after the 3rd payload; next header accepted the following cycle.
- Backpressure: drop `host_cmd_ready` for 5 cycles on payload B -> B held stable with valid=1, `pl_ready`=0, `busy`=1; no beat lost or duplicated; `beats_sent` ends at 4.
- Timeout: `STALL_LIMIT`=8, ready held 0 with a beat pending -> `stall_timeout` rises on the 8th stalled cycle's edge and stays 1 after ready returns.
- Sequence wrap: `SEQ_W`=4, send 17 zero-length packets -> header seq fields 0..15 then 0; `seq_num` reads 1 afterward.
